// File: rtl/step_counter.sv
// step_counter: registered up/down counter with programmable step, modulus,
// synchronous load and a one-cycle wrap pulse.
// Optional build macro COUNT_SATURATE_EN: clamp at 0/MAX instead of wrapping.
// In that build, wrap becomes a saturation flag. The port list does not change.
module step_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = (1 << WIDTH) - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             tc
);

    // One extra bit of headroom so sums and borrows never overflow silently.
    localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
`ifndef COUNT_SATURATE_EN
    localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MAX + 1);
`endif

    logic [WIDTH:0]   count_x;
    logic [WIDTH:0]   step_x;
    logic [WIDTH:0]   step_eff;
    logic [WIDTH:0]   sum_x;
    logic [WIDTH:0]   load_x;
    logic [WIDTH-1:0] count_n;
    logic             wrap_n;

    assign count_x  = {1'b0, count};
    assign step_x   = {1'b0, step};
    assign load_x   = {1'b0, load_val};
    // Oversized steps are clamped to MAX so one update never crosses more than one period.
    assign step_eff = (step_x > MAX_X) ? MAX_X : step_x;
    assign sum_x    = count_x + step_eff;

    // Next count and wrap/saturation flag; load outranks the enabled step.
    always_comb begin
        count_n = count;
        wrap_n  = 1'b0;
        if (load) begin
            count_n = (load_x > MAX_X) ? MAX_W : load_val;
        end else if (en) begin
            if (up_dn) begin
                if (sum_x > MAX_X) begin
`ifdef COUNT_SATURATE_EN
                    count_n = MAX_W;
`else
                    count_n = WIDTH'(sum_x - MOD_X);
`endif
                    wrap_n  = 1'b1;
                end else begin
                    count_n = WIDTH'(sum_x);
                end
            end else begin
                if (step_eff > count_x) begin
`ifdef COUNT_SATURATE_EN
                    count_n = '0;
`else
                    count_n = WIDTH'(count_x + MOD_X - step_eff);
`endif
                    wrap_n  = 1'b1;
                end else begin
                    count_n = WIDTH'(count_x - step_eff);
                end
            end
        end
    end

    // Count and wrap registers; synchronous reset drops any pending step.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_n;
            wrap  <= wrap_n;
        end
    end

    // Terminal count follows the current direction without a register stage.
    assign tc = up_dn ? (count == MAX_W) : (count == '0);

endmodule
